// File: rtl/iob_merge_arb.sv
// iob_merge_arb: merges N IOb masters onto one follower port.
// A built-in arbiter (round-robin or fixed priority) picks the master, the
// grant is held while a request stalls, and an ID FIFO remembers the issuer
// of every outstanding read so responses are steered back to their owner.
module iob_merge_arb #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int N       = 2,
    parameter int NB      = $clog2(N),
    parameter int PRIO    = 0,
    parameter int MAX_OUT = 4
) (
    input  logic                       clk_i,
    input  logic                       cke_i,
    input  logic                       arst_n_i,
    input  logic [N-1:0]               m_avalid_i,
    input  logic [N*ADDR_W-1:0]        m_addr_i,
    input  logic [N*DATA_W-1:0]        m_wdata_i,
    input  logic [N*(DATA_W/8)-1:0]    m_wstrb_i,
    output logic [N*DATA_W-1:0]        m_rdata_o,
    output logic [N-1:0]               m_rvalid_o,
    output logic [N-1:0]               m_ready_o,
    output logic                       f_avalid_o,
    output logic [ADDR_W-1:0]          f_addr_o,
    output logic [DATA_W-1:0]          f_wdata_o,
    output logic [DATA_W/8-1:0]        f_wstrb_o,
    input  logic [DATA_W-1:0]          f_rdata_i,
    input  logic                       f_rvalid_i,
    input  logic                       f_ready_i,
    output logic                       err_o
);

    localparam int  SW    = DATA_W / 8;
    localparam int  FW    = $clog2(MAX_OUT);
    localparam bit  FIXED = (PRIO != 0);
    localparam logic [FW:0] FULL_LVL = (FW+1)'(MAX_OUT);

    // Arbitration and hold state
    logic          lock;
    logic [NB-1:0] gnt_q;
    logic [NB-1:0] rr_ptr;

    // Outstanding-read ID FIFO
    logic [NB-1:0] id_mem [MAX_OUT];
    logic [FW-1:0] wr_ptr;
    logic [FW-1:0] rd_ptr;
    logic [FW:0]   count;
    logic          err;

    // Combinational routing signals
    logic [NB-1:0] arb_gnt;
    logic [NB-1:0] gnt;
    logic          g_valid;
    logic [ADDR_W-1:0] g_addr;
    logic [DATA_W-1:0] g_wdata;
    logic [SW-1:0]     g_wstrb;
    logic          g_read;
    logic          fifo_full;
    logic          fifo_empty;
    logic          stall;
    logic          accept;
    logic          push;
    logic          pop;
    logic [NB-1:0] head;

    // Picks the winning requester. Round-robin rotates the request vector so
    // the search starts at rr_ptr; fixed priority searches from index 0.
    // With nobody requesting the search start is returned, so the idle grant
    // is rr_ptr (round-robin) or 0 (fixed priority).
    function automatic logic [NB-1:0] pick(input logic [N-1:0]  req,
                                           input logic [NB-1:0] start);
        logic [2*N-1:0] dbl;
        logic [N-1:0]   rot;
        logic [NB:0]    idx;
        logic [NB-1:0]  sel;
        logic           found;
        dbl   = {req, req};
        rot   = FIXED ? req : dbl[start +: N];
        sel   = FIXED ? '0 : start;
        idx   = '0;
        found = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (!found && rot[j]) begin
                found = 1'b1;
                idx   = FIXED ? (NB+1)'(j) : {1'b0, start} + (NB+1)'(j);
                if (idx >= (NB+1)'(N)) idx = idx - (NB+1)'(N);
                sel = idx[NB-1:0];
            end
        end
        return sel;
    endfunction

    // Grant selection, request mux, stall and handshake generation
    always_comb begin
        arb_gnt = pick(m_avalid_i, rr_ptr);
        gnt     = lock ? gnt_q : arb_gnt;

        g_valid = 1'b0;
        g_addr  = '0;
        g_wdata = '0;
        g_wstrb = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt == NB'(i)) begin
                g_valid = m_avalid_i[i];
                g_addr  = m_addr_i[i*ADDR_W +: ADDR_W];
                g_wdata = m_wdata_i[i*DATA_W +: DATA_W];
                g_wstrb = m_wstrb_i[i*SW +: SW];
            end
        end

        g_read     = (g_wstrb == '0);
        fifo_full  = (count == FULL_LVL);
        fifo_empty = (count == '0);
        // A pop in this cycle does not free a slot for a read in the same cycle
        stall      = g_read & fifo_full;

        // Handshake outputs are held quiet while reset is asserted
        f_avalid_o = arst_n_i & g_valid & ~stall;
        f_addr_o   = stall ? '0 : g_addr;
        f_wdata_o  = stall ? '0 : g_wdata;
        f_wstrb_o  = stall ? '0 : g_wstrb;

        accept = f_avalid_o & f_ready_i;
        push   = accept & g_read;
        pop    = f_rvalid_i & ~fifo_empty;
        head   = id_mem[rd_ptr];

        for (int i = 0; i < N; i++) begin
            m_ready_o[i]  = arst_n_i & (gnt == NB'(i)) & f_ready_i & ~stall;
            m_rvalid_o[i] = arst_n_i & pop & (head == NB'(i));
        end

        m_rdata_o = {N{f_rdata_i}};
        err_o     = err;
    end

    // Lock, round-robin pointer, FIFO pointers/level and sticky error
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            lock   <= 1'b0;
            gnt_q  <= '0;
            rr_ptr <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            err    <= 1'b0;
        end else if (cke_i) begin
            if (accept) begin
                lock   <= 1'b0;
                rr_ptr <= (gnt == NB'(N-1)) ? '0 : gnt + NB'(1);
            end else if (g_valid) begin
                lock  <= 1'b1;
                gnt_q <= gnt;
            end else begin
                lock <= 1'b0;
            end

            if (push) wr_ptr <= wr_ptr + FW'(1);
            if (pop)  rd_ptr <= rd_ptr + FW'(1);

            if (push && !pop)      count <= count + (FW+1)'(1);
            else if (pop && !push) count <= count - (FW+1)'(1);

            if (f_rvalid_i && fifo_empty) err <= 1'b1;
        end
    end

    // ID storage: records the issuing master of each accepted read
    always_ff @(posedge clk_i) begin
        if (cke_i && push) id_mem[wr_ptr] <= gnt;
    end

endmodule
